// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the fetch stage: 2-bit branch counters,
// their saturating update, and default parameter values.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          BTB_IDX_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its surroundings: instruction memory,
// the IF/ID payload, hazard stall, and branch resolution from EX.
interface fetch_unit_if;
  // ex_valid is a one-cycle valid with no ready: fetch always accepts a
  // resolved branch in the cycle it is presented, even while stalled.
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PredictJump;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_predicted;
  logic        flush;

  modport master (
    input  stall, imem_rdata, ex_valid, ex_pc, ex_taken, ex_target, ex_predicted,
    output imem_addr, IR, PC, PCPlus4, PredictJump, flush
  );

  modport slave (
    output stall, imem_rdata, ex_valid, ex_pc, ex_taken, ex_target, ex_predicted,
    input  imem_addr, IR, PC, PCPlus4, PredictJump, flush
  );
endinterface

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup, edge-triggered
// update from branch resolution, synchronous clear on reset.
module btb_direct_mapped
  import fetch_unit_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W_DEFAULT,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic             rd_taken,
  output logic [31:0]      rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [31:0]      wr_target
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  ctr_t             ctr_q    [N];

  logic wr_hit;

  // Lookup sees registered contents only, so an entry written this edge
  // is reported with its old value for the whole current cycle.
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken  = rd_hit && ctr_q[rd_idx][1];
  assign rd_target = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        if (wr_taken) target_q[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        // Allocation replaces whatever aliased entry lives at this index.
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        ctr_q[wr_idx]    <= WT;
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BTB-driven next-PC prediction and
// mispredict redirect from EX.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int TAG_W = 30 - BTB_IDX_W;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pred_next;
  logic [31:0] redirect_pc;
  logic        btb_hit;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic        mis;

  btb_direct_mapped #(
    .IDX_W (BTB_IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_q[BTB_IDX_W+1:2]),
    .rd_tag    (pc_q[31:BTB_IDX_W+2]),
    .rd_hit    (btb_hit),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (bus.ex_valid),
    .wr_idx    (bus.ex_pc[BTB_IDX_W+1:2]),
    .wr_tag    (bus.ex_pc[31:BTB_IDX_W+2]),
    .wr_taken  (bus.ex_taken),
    .wr_target (bus.ex_target)
  );

  assign pc_plus4    = pc_q + 32'd4;
  assign pred_next   = btb_taken ? btb_target : pc_plus4;
  assign mis         = bus.ex_valid && (bus.ex_taken != bus.ex_predicted);
  assign redirect_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);

  // Reset beats redirect, redirect beats stall, stall beats prediction.
  always_ff @(posedge clk) begin
    if (reset)          pc_q <= RESET_PC;
    else if (mis)       pc_q <= redirect_pc;
    else if (bus.stall) pc_q <= pc_q;
    else                pc_q <= pred_next;
  end

  assign bus.imem_addr   = pc_q;
  assign bus.IR          = bus.imem_rdata;
  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.PredictJump = btb_taken;
  assign bus.flush       = mis;

  logic unused_hit;
  assign unused_hit = btb_hit;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, stall, BTB allocate/decay,
// redirect priority, aliasing, PC wrap and mid-run reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BTB_IDX_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hA5A5_0F0F;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_pj);
    chk({tag, "_pc"}, bus.PC, exp_pc);
    chk({tag, "_addr"}, bus.imem_addr, exp_pc);
    chk({tag, "_pc4"}, bus.PCPlus4, exp_pc + 32'd4);
    chk({tag, "_ir"}, bus.IR, mem_word(exp_pc));
    chk({tag, "_pj"}, {31'd0, bus.PredictJump}, {31'd0, exp_pj});
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic taken,
                          input logic [31:0] target, input logic pred);
    bus.ex_valid     = v;
    bus.ex_pc        = pc;
    bus.ex_taken     = taken;
    bus.ex_target    = target;
    bus.ex_predicted = pred;
    #1;
  endtask

  task automatic chk_flush(input string tag, input logic exp);
    chk(tag, {31'd0, bus.flush}, {31'd0, exp});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.stall = 1'b0;
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset held for two edges
    step();
    chk_pc("rst1", 32'h0, 1'b0);
    chk_flush("rst1_flush", 1'b0);
    step();
    chk_pc("rst2", 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk_pc("rel0", 32'h0, 1'b0);
    step();
    chk_pc("rel4", 32'h4, 1'b0);
    step();
    chk_pc("rel8", 32'h8, 1'b0);

    // Stall holds PC at 0x8
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pc("stall", 32'h8, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    chk_pc("unstall", 32'hC, 1'b0);

    // Allocate taken branch at 0x10 -> 0x40
    drive_ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
    chk_flush("alloc_flush", 1'b1);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("alloc_redir", 32'h40, 1'b0);
    chk_flush("alloc_noflush", 1'b0);
    drive_ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("hit10", 32'h10, 1'b1);
    step();
    chk_pc("pred40", 32'h40, 1'b0);

    // Decay: 0x10 resolves not-taken, counter 10 -> 01
    drive_ex(1'b1, 32'h10, 1'b0, 32'h40, 1'b1);
    chk_flush("decay_flush", 1'b1);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("decay_redir", 32'h14, 1'b0);
    drive_ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("weak10", 32'h10, 1'b0);
    step();
    chk_pc("weak14", 32'h14, 1'b0);

    // Mispredict wins over stall
    bus.stall = 1'b1;
    drive_ex(1'b1, 32'h20, 1'b1, 32'h80, 1'b0);
    chk_flush("prio_flush", 1'b1);
    step();
    chk_pc("prio_redir", 32'h80, 1'b0);
    // Correctly predicted resolution updates without flush: 0x10 counter 01 -> 10
    bus.stall = 1'b0;
    drive_ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b1);
    chk_flush("nomis_flush", 1'b0);
    step();
    chk_pc("seq84", 32'h84, 1'b0);
    drive_ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1);
    step();
    chk_pc("rehit10", 32'h10, 1'b1);
    // Redirect overrides the prediction at 0x10; 0x50 aliases index 4
    drive_ex(1'b1, 32'h4C, 1'b0, 32'h0, 1'b1);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("alias50", 32'h50, 1'b0);

    // Wrap at top of address space
    drive_ex(1'b1, 32'h30, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("wrap_fc", 32'hFFFF_FFFC, 1'b0);
    chk("wrap_pc4", bus.PCPlus4, 32'h0);
    step();
    chk_pc("wrap_0", 32'h0, 1'b0);
    step();
    chk_pc("wrap_4", 32'h4, 1'b0);

    // Reset together with a mispredict
    reset = 1'b1;
    drive_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    chk_flush("mrst_flush", 1'b1);
    step();
    reset = 1'b0;
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("mrst_pc", 32'h0, 1'b0);
    chk_flush("mrst_noflush", 1'b0);
    step();
    chk_pc("mrst_4", 32'h4, 1'b0);
    step();
    chk_pc("mrst_8", 32'h8, 1'b0);
    step();
    chk_pc("mrst_c", 32'hC, 1'b0);
    step();
    chk_pc("mrst_10", 32'h10, 1'b0);
    drive_ex(1'b1, 32'h1C, 1'b0, 32'h0, 1'b1);
    step();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_pc("mrst_20", 32'h20, 1'b0);
    step();
    chk_pc("mrst_24", 32'h24, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
